mips_multicycle_ctrl: RTL

//  Multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback.
//  It is the producer side of the ALU control interface: it drives the 6-bit ALU control

---
 rtl/mips_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU control and datapath strobes, raises illegal-op/overflow/bus-timeout exceptions.
module mips_multicycle_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MEM_TO_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             mem_ready,
    output logic [5:0]       alu_control,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             exc_valid,
    output logic [1:0]       exc_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(MEM_TO_MAX + 1);

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, EX_R, EX_I, ADDR, MRD, MWB, MWR, WB, BR, JMP, EXC
    } state_t;

    state_t        state, nxt;
    logic [TW-1:0] wait_cnt;
    logic          ovf_q;
    logic          rd_q;
    logic          waiting;
    logic          timeout;
    logic          ret_inc;
    logic          exc_go;
    logic [1:0]    cause_nxt;
    logic          r_ok;

    assign waiting = (state == FETCH) || (state == MRD) || (state == MWR);
    assign timeout = waiting && (wait_cnt == TW'(MEM_TO_MAX));
    assign r_ok    = (opcode == 6'd0) &&
                     (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                      funct == 6'd37 || funct == 6'd39 || funct == 6'd42);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST;
            wait_cnt  <= '0;
            ovf_q     <= 1'b0;
            rd_q      <= 1'b0;
            exc_cause <= 2'b00;
            retired   <= '0;
        end else begin
            state <= nxt;
            if (!waiting || mem_ready || nxt != state)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            // Overflow only traps for the signed adds (add / addi).
            if (state == EX_R) begin
                ovf_q <= alu_overflow && (funct == 6'd32);
                rd_q  <= 1'b1;
            end else if (state == EX_I) begin
                ovf_q <= alu_overflow && (opcode == 6'd8);
                rd_q  <= 1'b0;
            end
            if (exc_go)
                exc_cause <= cause_nxt;
            if (ret_inc)
                retired <= retired + 1'b1;
        end
    end

    always_comb begin
        nxt         = state;
        alu_control = 6'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        exc_valid   = 1'b0;
        ret_inc     = 1'b0;
        exc_go      = 1'b0;
        cause_nxt   = 2'b00;
        case (state)
            RST: nxt = FETCH;
            FETCH: begin
                alu_src_b   = 2'd1;
                alu_control = 6'd32;
                if (timeout) begin
                    nxt       = EXC;
                    exc_go    = 1'b1;
                    cause_nxt = 2'b11;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = DECODE;
                    end
                end
            end
            DECODE: begin
                alu_src_b   = 2'd3;
                alu_control = 6'd32;
                if (r_ok)
                    nxt = EX_R;
                else if (opcode == 6'd8 || opcode == 6'd10 || opcode == 6'd12 || opcode == 6'd13)
                    nxt = EX_I;
                else if (opcode == 6'd35 || opcode == 6'd43)
                    nxt = ADDR;
                else if (opcode == 6'd4 || opcode == 6'd5)
                    nxt = BR;
                else if (opcode == 6'd2)
                    nxt = JMP;
                else begin
                    nxt       = EXC;
                    exc_go    = 1'b1;
                    cause_nxt = 2'b01;
                end
            end
            EX_R: begin
                alu_src_a   = 1'b1;
                alu_control = funct;
                nxt         = WB;
            end
            EX_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'd2;
                alu_control = opcode;
                nxt         = WB;
            end
            WB: begin
                reg_dst = rd_q;
                if (ovf_q) begin
                    nxt       = EXC;
                    exc_go    = 1'b1;
                    cause_nxt = 2'b10;
                end else begin
                    reg_write = 1'b1;
                    ret_inc   = 1'b1;
                    nxt       = FETCH;
                end
            end
            ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'd2;
                alu_control = 6'd32;
                nxt         = (opcode == 6'd43) ? MWR : MRD;
            end
            MRD, MWR: begin
                iord = 1'b1;
                if (timeout) begin
                    nxt       = EXC;
                    exc_go    = 1'b1;
                    cause_nxt = 2'b11;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (state == MWR);
                    if (mem_ready) begin
                        nxt     = (state == MWR) ? FETCH : MWB;
                        ret_inc = (state == MWR);
                    end
                end
            end
            MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                ret_inc    = 1'b1;
                nxt        = FETCH;
            end
            BR: begin
                alu_src_a   = 1'b1;
                alu_control = opcode;
                pc_write    = alu_zero;
                pc_src      = 2'd1;
                ret_inc     = 1'b1;
                nxt         = FETCH;
            end
            JMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                ret_inc  = 1'b1;
                nxt      = FETCH;
            end
            EXC: begin
                exc_valid = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 2'd3;
                nxt       = FETCH;
            end
            default: nxt = RST;
        endcase
    end

endmodule
